affine_seq: RTL
===============

AFFINE_SEQ -- requirements
Module: affine_seq

Interface
REQ-001 SHALL take parameter N from package affine as the datapath width, with no local default.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port start_i, input, 1 bit: begin a run; sampled only in IDLE.
REQ-005 SHALL have port abort_i, input, 1 bit: terminate the run from any state.
REQ-006 SHALL have port num_samples_i, input, 8 bits: samples per run; captured on start.
REQ-007 SHALL have port smp_valid_i, input, 1 bit, and port smp_data_i, input, N bits: sample input handshake and data.
REQ-008 SHALL have port smp_ready_o, output, 1 bit: ready to accept a sample.
REQ-009 SHALL have port pc_o, output, PC_W bits: program ROM address; the ROM read is asynchronous.
REQ-010 SHALL have port instr_i, input, instr_t: the ROM word at pc_o.
REQ-011 SHALL have port ext_data_o, output, N bits: held sample; drives the register file external input.
REQ-012 SHALL have the following register file control outputs, all registered:
- rs_addr_o, output, 3 bits;
- rd_addr_o, output, 3 bits;
- wdual_o, output, 1 bit;
- op_o, output, OP_W bits.
REQ-013 SHALL have the following status outputs, all registered:
- busy_o, output, 1 bit;
- done_o, output, 1 bit: one-cycle pulse;
- err_o, output, 1 bit: sticky.

Function
REQ-014 SHALL implement the states IDLE, LOAD, SETTLE, EXEC, DRAIN and DONE.
REQ-015 In IDLE, start_i SHALL capture num_samples_i, clear the sample count and clear err_o.
- If num_samples_i is 0, the next state SHALL be DONE.
- Otherwise the next state SHALL be LOAD.
REQ-016 In LOAD, smp_ready_o SHALL be 1, and in every other state it SHALL be 0.
REQ-017 A LOAD transfer (smp_valid_i and smp_ready_o both 1) SHALL register smp_data_i into ext_data_o and move to SETTLE.
REQ-018 ext_data_o SHALL hold its value until the next transfer.
REQ-019 SETTLE SHALL last exactly one cycle, so the register file has latched ext_data_o before any issue; it then SHALL move to EXEC with pc cleared to 0.
REQ-020 In EXEC, on each cycle the issue register SHALL load instr_i fields (rs, rd, dual, op) and pc SHALL increment by 1.
REQ-021 Issue latency SHALL be exactly 1 cycle: the word at pc_o = p appears on the control outputs in the cycle after pc_o = p.
REQ-022 A fetched word with last=1 SHALL be issued, and the next state SHALL be DRAIN with no further fetch.
REQ-023 If pc = 2^PC_W-1 and the fetched word has last=0, that word SHALL be issued as if last=1, and err_o SHALL be set.
REQ-024 DRAIN SHALL load NOP into the issue register and increment the sample count.
- If the incremented count equals the captured num_samples_i, the next state SHALL be DONE.
- Otherwise the next state SHALL be LOAD.
REQ-025 DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-026 NOP SHALL be rs=3, rd=3, dual=0, op=OP_NOP.
- Address 3 reads zero and writes nothing.
- The control outputs SHALL equal NOP in every state except the cycle after an EXEC fetch.
REQ-027 A fetched word with dual=0 and rd in {0,3,5,6,7} SHALL be issued as NOP with err_o set; rd=0 is the read-only external register.
REQ-028 A fetched word with rs in {3,5,6,7} SHALL set err_o and SHALL still be issued unchanged.
REQ-029 Control outputs SHALL change only on the rising edge, so wdual_o and rd_addr_o are stable across the falling edge where the second accumulator writes.
REQ-030 abort_i SHALL take priority over every other transition.
- The next state SHALL be IDLE and the issue register SHALL become NOP.
- done_o SHALL NOT pulse and err_o SHALL be retained.
REQ-031 busy_o SHALL be 1 in every state except IDLE.
REQ-032 start_i outside IDLE SHALL be ignored.

Reset
REQ-033 rst_i SHALL, asynchronously, put the block in IDLE with:
- pc=0 and sample count 0;
- ext_data_o=0 and the issue register at NOP;
- busy_o=0, done_o=0, err_o=0, smp_ready_o=0.
REQ-034 A reset mid-run SHALL discard the run entirely, and no done_o SHALL follow reset release.

Structure
REQ-035 Package affine SHALL hold the following:
- PC_W=5;
- OP_W=3 and the OP_* encodings, including OP_NOP=0;
- instr_t, a packed struct {op[OP_W], rs[3], rd[3], dual[1], last[1]};
- constant NOP_INSTR;
- the state enum type.
REQ-036 The block SHALL be a single module with no sub-modules; the instruction-legality check SHALL be a package function.

Verification
REQ-037 A bench SHALL run a single sample through a 3-word program ending last=1:
- required response: control outputs show the 3 words in order, with 1-cycle latency after SETTLE;
- required response: one NOP DRAIN cycle, then done_o one cycle, then IDLE.
REQ-038 A bench SHALL run num_samples=2 with smp_valid_i held low for 3 cycles in LOAD: smp_ready_o SHALL stay 1 with no issue, and exactly 2 program passes SHALL occur before done_o.
REQ-039 A bench SHALL start with num_samples=0: DONE SHALL follow on the next cycle, with no smp_ready_o and no issue.
REQ-040 A bench SHALL issue a word with rd=0 and dual=0: it SHALL go out as NOP, err_o SHALL be 1, and the run SHALL complete.
REQ-041 A bench SHALL run a 32-word program with no last bit: after pc=31 is issued, err_o SHALL be 1, and DRAIN then DONE SHALL follow.
REQ-042 A bench SHALL assert abort_i in EXEC, and separately rst_i mid-EXEC:
- abort: IDLE next cycle, outputs NOP, no done_o;
- reset: all reset values immediately.

Source files
------------

// File: rtl/affine_seq_pkg.sv
// Shared types and constants for the affine sequencer.
// Holds the datapath width, program ROM word layout, opcodes and state encoding.
// Also hosts the instruction legality check used at issue time.
package affine;

  localparam int N    = 16;
  localparam int PC_W = 5;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD = 3'd1;
  localparam logic [OP_W-1:0] OP_SUB = 3'd2;
  localparam logic [OP_W-1:0] OP_MUL = 3'd3;
  localparam logic [OP_W-1:0] OP_MAC = 3'd4;
  localparam logic [OP_W-1:0] OP_MOV = 3'd5;
  localparam logic [OP_W-1:0] OP_NEG = 3'd6;
  localparam logic [OP_W-1:0] OP_SHR = 3'd7;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [2:0]      rs;
    logic [2:0]      rd;
    logic            dual;
    logic            last;
  } instr_t;

  // Address 3 reads as zero and swallows writes, so this is a true no-op.
  localparam instr_t NOP_INSTR = '{op: OP_NOP, rs: 3'd3, rd: 3'd3, dual: 1'b0, last: 1'b0};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_EXEC   = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic squash;  // issue a NOP in place of this word
    logic err;     // word is malformed in some way
  } chk_t;

  // Single-write words may not target the read-only external register (0),
  // the zero register (3) or the unpopulated addresses 5..7. Bad sources are
  // only flagged; the register file reads them harmlessly.
  function automatic chk_t instr_check(instr_t i);
    chk_t c;
    logic rd_bad;
    logic rs_bad;
    rd_bad   = (i.rd == 3'd0) || (i.rd == 3'd3) || (i.rd >= 3'd5);
    rs_bad   = (i.rs == 3'd3) || (i.rs >= 3'd5);
    c.squash = !i.dual && rd_bad;
    c.err    = c.squash || rs_bad;
    return c;
  endfunction

endpackage

// File: rtl/affine_seq_if.sv
// Sample input stream for the affine sequencer.
// Plain valid/ready: a transfer happens on a rising edge with both high.
// The producer holds data stable while valid is high and ready is low.
interface affine_seq_if;
  import affine::*;

  logic         smp_valid_i;
  logic [N-1:0] smp_data_i;
  logic         smp_ready_o;

  modport master (output smp_valid_i, output smp_data_i, input smp_ready_o);
  modport slave  (input smp_valid_i, input smp_data_i, output smp_ready_o);

endinterface

// File: rtl/affine_seq.sv
// Sample-driven microsequencer: loads one sample, runs the ROM program over it, repeats.
// Latency: ROM word at pc_o appears on the control outputs exactly one cycle later.
// Backpressure: sample ready is high only in LOAD; the block waits there indefinitely.
module affine_seq
  import affine::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [7:0]      num_samples_i,
  affine_seq_if.slave     smp,
  output logic [PC_W-1:0] pc_o,
  input  instr_t          instr_i,
  output logic [N-1:0]    ext_data_o,
  output logic [2:0]      rs_addr_o,
  output logic [2:0]      rd_addr_o,
  output logic            wdual_o,
  output logic [OP_W-1:0] op_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [7:0]      cnt, cnt_n;
  logic [7:0]      num, num_n;
  logic [N-1:0]    ext, ext_n;
  logic [OP_W-1:0] op_q, op_n;
  logic [2:0]      rs_q, rs_n;
  logic [2:0]      rd_q, rd_n;
  logic            dual_q, dual_n;
  logic            err_q, err_n;
  logic            busy_q, ready_q, done_q;
  chk_t            chk;

  // Next-state, datapath and issue decode; issue register defaults to NOP.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    num_n   = num;
    ext_n   = ext;
    op_n    = NOP_INSTR.op;
    rs_n    = NOP_INSTR.rs;
    rd_n    = NOP_INSTR.rd;
    dual_n  = NOP_INSTR.dual;
    err_n   = err_q;
    chk     = instr_check(instr_i);

    if (abort_i) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            num_n   = num_samples_i;
            cnt_n   = 8'd0;
            err_n   = 1'b0;
            state_n = (num_samples_i == 8'd0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (smp.smp_valid_i && ready_q) begin
            ext_n   = smp.smp_data_i;
            state_n = S_SETTLE;
          end
        end
        S_SETTLE: begin
          // One idle cycle lets the register file capture ext_data_o first.
          pc_n    = '0;
          state_n = S_EXEC;
        end
        S_EXEC: begin
          if (!chk.squash) begin
            op_n   = instr_i.op;
            rs_n   = instr_i.rs;
            rd_n   = instr_i.rd;
            dual_n = instr_i.dual;
          end
          err_n = err_q | chk.err;
          pc_n  = pc + 1'b1;
          if (instr_i.last || (pc == '1)) begin
            // Running off the end of the ROM is treated as an implicit last.
            if (!instr_i.last) err_n = 1'b1;
            state_n = S_DRAIN;
          end
        end
        S_DRAIN: begin
          cnt_n   = cnt + 8'd1;
          state_n = (cnt_n == num) ? S_DONE : S_LOAD;
        end
        S_DONE: begin
          state_n = S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; status flags are derived from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      pc      <= '0;
      cnt     <= 8'd0;
      num     <= 8'd0;
      ext     <= '0;
      op_q    <= NOP_INSTR.op;
      rs_q    <= NOP_INSTR.rs;
      rd_q    <= NOP_INSTR.rd;
      dual_q  <= NOP_INSTR.dual;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      cnt     <= cnt_n;
      num     <= num_n;
      ext     <= ext_n;
      op_q    <= op_n;
      rs_q    <= rs_n;
      rd_q    <= rd_n;
      dual_q  <= dual_n;
      err_q   <= err_n;
      busy_q  <= (state_n != S_IDLE);
      ready_q <= (state_n == S_LOAD);
      done_q  <= (state_n == S_DONE);
    end
  end

  assign pc_o            = pc;
  assign ext_data_o      = ext;
  assign op_o            = op_q;
  assign rs_addr_o       = rs_q;
  assign rd_addr_o       = rd_q;
  assign wdual_o         = dual_q;
  assign err_o           = err_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign smp.smp_ready_o = ready_q;

endmodule
